// File: rtl/fpu_normalize_pipe.sv
// fpu_normalize_pipe: two-stage leading-zero normaliser for an FPU datapath.
// Counts the leading zeros of an unnormalised significand (carry bit at
// IN_W-1, hidden bit at IN_W-2), shifts the leading one into the hidden-bit
// position, adjusts the biased exponent and flags zero/underflow/overflow.
// Optional macro FPU_NORM_STICKY_EN: adds a sticky output reporting the LSB
// dropped when no left shift is needed (carry-out case).
module fpu_normalize_pipe #(
  parameter int IN_W  = 25,
  parameter int EXP_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_W-1:0]            in_value,
  input  logic [EXP_W-1:0]           in_exp,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IN_W-3:0]            out_man,
  output logic [$clog2(IN_W+1)-1:0]  out_shift,
  output logic [EXP_W-1:0]           out_exp,
  output logic                       out_zero,
  output logic                       out_uflow,
  output logic                       out_oflow,
  output logic                       out_sticky
);

  localparam int MAN_W = IN_W - 2;
  localparam int SH_W  = $clog2(IN_W + 1);
  // Shift-count bits below LO_W are applied in stage 2, the rest in stage 1.
  localparam int LO_W  = SH_W / 2;
  localparam int EW2   = EXP_W + 2;

  localparam logic signed [EW2-1:0] E_ZERO = '0;
  localparam logic signed [EW2-1:0] E_MAX  = EW2'((1 << EXP_W) - 1);

  // Pipeline control: stage 2 can load when empty or being drained; stage 1
  // can load when empty or when it moves into stage 2.
  logic s1_valid;
  logic s2_en;
  logic s1_en;

  assign s2_en    = !out_valid || out_ready;
  assign s1_en    = s2_en || !s1_valid;
  assign in_ready = !rst && s1_en;

  // ---------------- stage 1 combinational ----------------
  logic [SH_W-1:0] lz0;
  logic [SH_W-1:0] hi_amt0;
  logic [IN_W-1:0] shl0;
  logic            zero0;

  // Leading-zero count (highest set bit wins) and upper shifter layers.
  always_comb begin
    lz0 = SH_W'(IN_W);
    for (int unsigned i = 0; i < IN_W; i++) begin
      if (in_value[i]) lz0 = SH_W'(IN_W - 1 - i);
    end
    hi_amt0              = lz0;
    hi_amt0[LO_W-1:0]    = '0;
    shl0                 = in_value << hi_amt0;
    zero0                = (in_value == '0);
  end

  logic [IN_W-1:0]  s1_val;
  logic [SH_W-1:0]  s1_lz;
  logic [EXP_W-1:0] s1_exp;
  logic             s1_zero;

  // Stage 1 register: partially shifted value, full lz and exponent.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_val   <= '0;
      s1_lz    <= '0;
      s1_exp   <= '0;
      s1_zero  <= 1'b0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_val  <= shl0;
        s1_lz   <= lz0;
        s1_exp  <= in_exp;
        s1_zero <= zero0;
      end
    end
  end

  // ---------------- stage 2 combinational ----------------
  logic [IN_W-1:0]        full2;
  logic [MAN_W-1:0]       man2;
  logic signed [EW2-1:0]  e_ext;
  logic signed [EW2-1:0]  lz_ext;
  logic signed [EW2-1:0]  e2;
  logic [EXP_W-1:0]       exp2;
  logic                   uflow2;
  logic                   oflow2;

  // Remaining shifter layers, exponent adjust and range flags.
  always_comb begin
    full2  = s1_val << s1_lz[LO_W-1:0];
    man2   = MAN_W'(full2 >> 1);
    e_ext  = {2'b00, s1_exp};
    lz_ext = EW2'(s1_lz);
    e2     = e_ext + EW2'(1) - lz_ext;
    uflow2 = 1'b0;
    oflow2 = 1'b0;
    exp2   = e2[EXP_W-1:0];
    if (s1_zero) begin
      exp2 = '0;
    end else if (e2 <= E_ZERO) begin
      uflow2 = 1'b1;
      exp2   = '0;
    end else if (e2 >= E_MAX) begin
      oflow2 = 1'b1;
      exp2   = '1;
    end
  end

  // Stage 2 register: final outputs, held while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_man   <= '0;
      out_shift <= '0;
      out_exp   <= '0;
      out_zero  <= 1'b0;
      out_uflow <= 1'b0;
      out_oflow <= 1'b0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_man   <= man2;
        out_shift <= s1_lz;
        out_exp   <= exp2;
        out_zero  <= s1_zero;
        out_uflow <= uflow2;
        out_oflow <= oflow2;
      end
    end
  end

`ifdef FPU_NORM_STICKY_EN
  logic s1_sticky;

  // Sticky travels with its beat: only the lz=0 case drops a bit (the LSB).
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_sticky  <= 1'b0;
      out_sticky <= 1'b0;
    end else begin
      if (s1_en && in_valid) s1_sticky  <= (lz0 == '0) && in_value[0];
      if (s2_en && s1_valid) out_sticky <= s1_sticky;
    end
  end
`else
  assign out_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_normalize_pipe.sv
// Self-checking bench for fpu_normalize_pipe (default parameters).
module tb_fpu_normalize_pipe;

`ifdef FPU_NORM_STICKY_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  typedef struct packed {
    logic [22:0] man;
    logic [4:0]  shift;
    logic [7:0]  exp;
    logic        zero;
    logic        uflow;
    logic        oflow;
    logic        sticky;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [24:0] in_value = '0;
  logic [7:0]  in_exp = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [22:0] out_man;
  logic [4:0]  out_shift;
  logic [7:0]  out_exp;
  logic        out_zero, out_uflow, out_oflow, out_sticky;
  res_t        dut_res;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpu_normalize_pipe #(.IN_W(25), .EXP_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_value(in_value), .in_exp(in_exp), .out_valid(out_valid),
    .out_ready(out_ready), .out_man(out_man), .out_shift(out_shift),
    .out_exp(out_exp), .out_zero(out_zero), .out_uflow(out_uflow),
    .out_oflow(out_oflow), .out_sticky(out_sticky)
  );

  assign dut_res = {out_man, out_shift, out_exp, out_zero, out_uflow, out_oflow, out_sticky};

  // Reference: find the leading one, take the bits beneath it as the
  // mantissa, and adjust the exponent with ordinary integer arithmetic.
  function automatic res_t model(input logic [24:0] v, input logic [7:0] ex);
    res_t r;
    int lz, p, e;
    r = '0;
    if (v == 0) begin
      r.zero  = 1'b1;
      r.shift = 5'd25;
      return r;
    end
    lz = 0;
    while (!v[24-lz]) lz++;
    p = 24 - lz;
    if (lz == 0) r.man = v[23:1];
    else         r.man = 23'((v & ((25'd1 << p) - 25'd1)) << (23 - p));
    r.shift = 5'(lz);
    e = int'(ex) + 1 - lz;
    if (e <= 0) r.uflow = 1'b1;
    else if (e >= 255) begin r.oflow = 1'b1; r.exp = 8'hFF; end
    else r.exp = 8'(e);
    r.sticky = STK && (lz == 0) && v[0];
    return r;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl out_valid=%b in_ready=%b want 0 0", out_valid, in_ready);
    end
    checks++;
    if (dut_res !== '0) begin
      errors++;
      $display("FAIL reset_data got %h want 0", dut_res);
    end
    rst = 1'b0;
    step;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release in_ready=%b want 1", in_ready);
    end
  endtask

  logic [24:0] dv [7] = '{25'h1000000, 25'h0C00000, 25'h0000001, 25'h0000000,
                          25'h1000000, 25'h1000001, 25'h0000003};
  logic [7:0]  dx [7] = '{8'd100, 8'd100, 8'd10, 8'd77, 8'd254, 8'd50, 8'd30};
  res_t        de [7] = '{
    {23'h000000, 5'd0,  8'd101, 4'b0000},
    {23'h400000, 5'd1,  8'd100, 4'b0000},
    {23'h000000, 5'd24, 8'd0,   4'b0100},
    {23'h000000, 5'd25, 8'd0,   4'b1000},
    {23'h000000, 5'd0,  8'hFF,  4'b0010},
    {23'h000000, 5'd0,  8'd51,  {3'b000, STK}},
    {23'h400000, 5'd23, 8'd8,   4'b0000}
  };

  task automatic test_directed;
    int n;
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      in_valid = 1'b1; in_value = dv[k]; in_exp = dx[k];
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL dir_ready[%0d] in_ready=%b want 1", k, in_ready);
      end
      step;
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 10) begin step; n++; end
      checks++;
      if (n != 2 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL dir_latency[%0d] cycles=%0d want 2", k, n);
      end
      checks++;
      if (dut_res !== de[k]) begin
        errors++;
        $display("FAIL dir_value[%0d] got %h want %h", k, dut_res, de[k]);
      end
      step;
    end
  endtask

  task automatic test_random_stream;
    res_t q[$];
    res_t exp_r, held;
    bit acc, xfer, hold;
    int guard;
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_value  = 25'($urandom) >> $urandom_range(0, 25);
      case ($urandom_range(0, 5))
        0: in_exp = 8'd0;
        1: in_exp = 8'd255;
        2: in_exp = 8'd254;
        default: in_exp = 8'($urandom_range(0, 255));
      endcase
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc  = in_valid && in_ready;
      xfer = out_valid && out_ready;
      if (xfer) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rnd_spurious got %h want no beat", dut_res);
        end else begin
          exp_r = q.pop_front();
          if (dut_res !== exp_r) begin
            errors++;
            $display("FAIL rnd_value got %h want %h", dut_res, exp_r);
          end
        end
      end
      if (acc) q.push_back(model(in_value, in_exp));
      hold = out_valid && !out_ready;
      held = dut_res;
      step;
      if (hold) begin
        checks++;
        if (out_valid !== 1'b1 || dut_res !== held) begin
          errors++;
          $display("FAIL rnd_hold valid=%b got %h want %h", out_valid, dut_res, held);
        end
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      #1;
      if (out_valid) begin
        checks++;
        exp_r = q.pop_front();
        if (dut_res !== exp_r) begin
          errors++;
          $display("FAIL rnd_drain got %h want %h", dut_res, exp_r);
        end
      end
      step;
      guard++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL rnd_lost remaining=%0d want 0", q.size());
    end
  endtask

  task automatic test_backpressure;
    logic [24:0] bp [4];
    logic [7:0]  be [4];
    int nacc, nout;
    res_t exp_r;
    for (int i = 0; i < 4; i++) begin
      bp[i] = 25'($urandom) >> $urandom_range(0, 20);
      be[i] = 8'($urandom_range(20, 230));
    end
    out_ready = 1'b0;
    nacc = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (nacc < 4);
      in_value = bp[nacc];
      in_exp   = be[nacc];
      #1;
      if (in_valid && in_ready) nacc++;
      step;
    end
    checks++;
    if (nacc != 2) begin
      errors++;
      $display("FAIL bp_accepted got %0d want 2", nacc);
    end
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_stall in_ready=%b out_valid=%b want 0 1", in_ready, out_valid);
    end
    exp_r = model(bp[0], be[0]);
    checks++;
    if (dut_res !== exp_r) begin
      errors++;
      $display("FAIL bp_held got %h want %h", dut_res, exp_r);
    end
    out_ready = 1'b1;
    nout = 0;
    for (int c = 0; c < 20 && nout < 4; c++) begin
      in_valid = (nacc < 4);
      in_value = bp[nacc % 4];
      in_exp   = be[nacc % 4];
      #1;
      if (out_valid) begin
        checks++;
        exp_r = model(bp[nout], be[nout]);
        if (dut_res !== exp_r) begin
          errors++;
          $display("FAIL bp_order[%0d] got %h want %h", nout, dut_res, exp_r);
        end
        nout++;
      end
      if (in_valid && in_ready) nacc++;
      step;
    end
    in_valid = 1'b0;
    checks++;
    if (nout != 4 || nacc != 4) begin
      errors++;
      $display("FAIL bp_count out=%0d acc=%0d want 4 4", nout, nacc);
    end
    step;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_dup out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      in_value = 25'($urandom) | 25'h0100000;
      in_exp   = 8'd90;
      step;
    end
    rst = 1'b1; in_valid = 1'b0;
    step;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset out_valid=%b in_ready=%b want 0 0", out_valid, in_ready);
    end
    rst = 1'b0; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_release in_ready=%b want 1", in_ready);
    end
    seen = 0;
    repeat (6) begin
      if (out_valid) seen++;
      step;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL mid_stale emitted=%0d want 0", seen);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_backpressure;
    test_random_stream;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
